// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
//   state_t  : sequencer states (IDLE, ISSUE, WAIT, CAPTURE, DONE)
//   DEFAULT_WIDTH / DEFAULT_LATENCY : default operand width and adder latency
//   cnt_w()  : width of the internal bit-index and wait counters
package serial_adder_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_LATENCY = 8;

  // One counter width serves both the bit index (up to WIDTH-1) and the
  // wait timer (up to LATENCY-2); never narrower than one bit.
  function automatic int cnt_w(input int latency, input int width);
    int m;
    m = (latency > width) ? latency : width;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/serial_adder_controller_lsb_shift_register.sv
// WIDTH-bit shift register that shifts toward bit 0, with parallel load.
//   clk, rst  : clock, synchronous active-high reset (clears q)
//   load      : parallel load of load_val (has priority over shift)
//   shift_en  : shift right one place, serial_in enters the MSB
//   q         : register contents
module lsb_shift_register
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shifted;

  // Built as shift-then-overwrite so WIDTH=1 needs no special case.
  always_comb begin
    shifted            = q >> 1;
    shifted[WIDTH-1]   = serial_in;
  end

  always_ff @(posedge clk) begin
    if (rst)           q <= '0;
    else if (load)     q <= load_val;
    else if (shift_en) q <= shifted;
  end

endmodule

// File: rtl/serial_adder_controller.sv
// Bit-serial sequencer wrapping an external clocked 1-bit full adder.
// Accepts WIDTH-bit operands plus carry-in, issues one bit pair per pass
// (LSB first) with a one-cycle fa_strobe, waits LATENCY cycles, captures
// fa_sum/fa_cout, feeds the carry back and assembles the result.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake; in_a, in_b, in_cin sampled on accept
//   out_valid/out_ready : result handshake; out_sum, out_cout held while pending
//   fa_a, fa_b, fa_cin  : bit pair and carry to the adder (held between strobes)
//   fa_strobe           : one-cycle clock enable to the adder
//   fa_sum, fa_cout     : adder outputs, valid LATENCY cycles after fa_strobe
//
// state   | meaning
// IDLE    | waiting for operands, in_ready=1
// ISSUE   | fa_strobe high for one bit, operand registers shift
// WAIT    | wait timer counting down adder latency
// CAPTURE | sample fa_sum/fa_cout, carry fed back
// DONE    | result presented until out_ready
module serial_adder_controller
  import serial_adder_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  output logic             fa_strobe,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CNT_W = cnt_w(LATENCY, WIDTH);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);

  state_t state, next_state;

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] bit_idx;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             accept, issue, capture;

  assign in_ready = (state == IDLE);
  assign accept   = in_ready && in_valid;
  assign issue    = (state == ISSUE);
  assign capture  = (state == CAPTURE);

  // Only bit 0 of the operand registers is ever read; the rest just
  // walks down into it.
  logic unused_sh;
  assign unused_sh = ^{a_q, b_q};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = ISSUE;
      ISSUE:   next_state = (LATENCY == 1) ? CAPTURE : WAIT;
      WAIT:    if (wait_cnt == '0) next_state = CAPTURE;
      CAPTURE: next_state = (bit_idx == LAST_BIT) ? DONE : ISSUE;
      DONE:    if (out_valid && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The adder drive is registered: the bit for the upcoming ISSUE cycle is
  // taken from the inputs on accept, or from the already-shifted operand
  // registers and the fresh fa_cout on capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      bit_idx   <= '0;
      carry     <= 1'b0;
      fa_a      <= 1'b0;
      fa_b      <= 1'b0;
      fa_cin    <= 1'b0;
      fa_strobe <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else begin
      fa_strobe <= (next_state == ISSUE);

      if (accept) begin
        bit_idx <= '0;
        carry   <= in_cin;
        fa_a    <= in_a[0];
        fa_b    <= in_b[0];
        fa_cin  <= in_cin;
      end

      if (issue)                wait_cnt <= WAIT_LOAD;
      else if (state == WAIT)   wait_cnt <= wait_cnt - 1'b1;

      if (capture) begin
        carry <= fa_cout;
        if (bit_idx != LAST_BIT) begin
          bit_idx <= bit_idx + 1'b1;
          fa_a    <= a_q[0];
          fa_b    <= b_q[0];
          fa_cin  <= fa_cout;
        end
      end

      // Result registers load on the first DONE cycle, then hold.
      if (state == DONE) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_sum   <= res_q;
          out_cout  <= carry;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  lsb_shift_register #(.WIDTH(WIDTH)) a_sh (
    .clk(clk), .rst(rst), .load(accept), .load_val(in_a),
    .shift_en(issue), .serial_in(1'b0), .q(a_q)
  );

  lsb_shift_register #(.WIDTH(WIDTH)) b_sh (
    .clk(clk), .rst(rst), .load(accept), .load_val(in_b),
    .shift_en(issue), .serial_in(1'b0), .q(b_q)
  );

  lsb_shift_register #(.WIDTH(WIDTH)) res_sh (
    .clk(clk), .rst(rst), .load(accept), .load_val({WIDTH{1'b0}}),
    .shift_en(capture), .serial_in(fa_sum), .q(res_q)
  );

endmodule

// File: tb/tb_serial_adder_controller.sv
module tb_serial_adder_controller;

  localparam int L8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic       in_valid8 = 1'b0, in_ready8, in_cin8 = 1'b0;
  logic [7:0] in_a8 = '0, in_b8 = '0, out_sum8;
  logic       out_valid8, out_ready8 = 1'b0, out_cout8;
  logic       fa_a8, fa_b8, fa_cin8, fa_strobe8, fa_sum8, fa_cout8;

  logic       in_valid1 = 1'b0, in_ready1, in_cin1 = 1'b0;
  logic [0:0] in_a1 = '0, in_b1 = '0, out_sum1;
  logic       out_valid1, out_ready1 = 1'b0, out_cout1;
  logic       fa_a1, fa_b1, fa_cin1, fa_strobe1, fa_sum1, fa_cout1;

  int checks = 0;
  int errors = 0;

  serial_adder_controller #(.WIDTH(8), .LATENCY(L8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_cin(in_cin8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_sum(out_sum8), .out_cout(out_cout8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_strobe(fa_strobe8),
    .fa_sum(fa_sum8), .fa_cout(fa_cout8)
  );

  serial_adder_controller #(.WIDTH(1), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_sum(out_sum1), .out_cout(out_cout1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_strobe(fa_strobe1),
    .fa_sum(fa_sum1), .fa_cout(fa_cout1)
  );

  // Behavioural full adders: computed on a strobe edge, result emerges
  // LATENCY cycles after the strobe cycle and is valid for that one cycle
  // only; every other slot carries alternating junk.
  logic       poison = 1'b0;
  logic [1:0] dl8 [L8];
  logic [1:0] dl1 = 2'b00;

  initial for (int i = 0; i < L8; i++) dl8[i] = 2'b00;

  always @(posedge clk) begin
    poison <= ~poison;
    dl8[0] <= fa_strobe8 ? {fa_a8 ^ fa_b8 ^ fa_cin8, (fa_a8 & fa_b8) | (fa_cin8 & (fa_a8 ^ fa_b8))}
                         : {poison, ~poison};
    for (int i = 1; i < L8; i++) dl8[i] <= dl8[i-1];
    dl1    <= fa_strobe1 ? {fa_a1 ^ fa_b1 ^ fa_cin1, (fa_a1 & fa_b1) | (fa_cin1 & (fa_a1 ^ fa_b1))}
                         : {~poison, poison};
  end

  assign fa_sum8  = dl8[L8-1][1];
  assign fa_cout8 = dl8[L8-1][0];
  assign fa_sum1  = dl1[1];
  assign fa_cout1 = dl1[0];

  // Strobe monitor
  int   cyc = 0;
  int   strobe_q [$];
  logic cin_q [$];
  int   strobe1_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fa_strobe8) begin
      strobe_q.push_back(cyc);
      cin_q.push_back(fa_cin8);
    end
    if (fa_strobe1) strobe1_cnt <= strobe1_cnt + 1;
  end

  // Drives one operation into dut8; returns the number of edges from the
  // accept edge until out_valid is seen high (-1 on timeout).
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
    int g;
    @(negedge clk);
    in_a8 = a; in_b8 = b; in_cin8 = c; in_valid8 = 1'b1;
    g = 0;
    while (!in_ready8 && g < 50) begin @(negedge clk); g++; end
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0; in_a8 = ~a; in_b8 = ~b; in_cin8 = ~c;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (out_valid8) begin lat = n; break; end
    end
  endtask

  task automatic run_op1(input logic a, input logic b, input logic c, output int lat);
    @(negedge clk);
    in_a1 = a; in_b1 = b; in_cin1 = c; in_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0; in_a1 = ~a; in_b1 = ~b; in_cin1 = ~c;
    lat = -1;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if (out_valid1) begin lat = n; break; end
    end
  endtask

  task automatic accept_out8();
    @(negedge clk); out_ready8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errors++; $display("FAIL accept8: out_valid=%0b in_ready=%0b required 0/1", out_valid8, in_ready8);
    end
    @(negedge clk); out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      errors++; $display("FAIL reset_hs8: in_ready=%0b out_valid=%0b required 1/0", in_ready8, out_valid8);
    end
    checks++;
    if (out_sum8 !== 8'h00 || out_cout8 !== 1'b0) begin
      errors++; $display("FAIL reset_out8: sum=%h cout=%0b required 00/0", out_sum8, out_cout8);
    end
    checks++;
    if ({fa_a8, fa_b8, fa_cin8, fa_strobe8} !== 4'b0000) begin
      errors++; $display("FAIL reset_fa8: got %b required 0000", {fa_a8, fa_b8, fa_cin8, fa_strobe8});
    end
    checks++;
    if ({in_ready1, out_valid1, out_sum1, out_cout1, fa_a1, fa_b1, fa_cin1, fa_strobe1} !== 8'b1000_0000) begin
      errors++; $display("FAIL reset_dut1: got %b required 10000000",
        {in_ready1, out_valid1, out_sum1, out_cout1, fa_a1, fa_b1, fa_cin1, fa_strobe1});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic_add();
    int lat, base, cnt;
    base = strobe_q.size();
    run_op8(8'h3C, 8'h05, 1'b0, lat);
    checks++;
    if (lat !== 73) begin errors++; $display("FAIL basic_latency: got %0d required 73", lat); end
    checks++;
    if (out_sum8 !== 8'h41 || out_cout8 !== 1'b0) begin
      errors++; $display("FAIL basic_sum: got %h/%0b required 41/0", out_sum8, out_cout8);
    end
    cnt = strobe_q.size() - base;
    checks++;
    if (cnt !== 8) begin errors++; $display("FAIL basic_strobes: got %0d required 8", cnt); end
    for (int i = base + 1; i < strobe_q.size(); i++) begin
      checks++;
      if (strobe_q[i] - strobe_q[i-1] !== 9) begin
        errors++; $display("FAIL basic_gap: got %0d required 9", strobe_q[i] - strobe_q[i-1]);
      end
    end
    accept_out8();
  endtask

  task automatic test_carry();
    int lat;
    run_op8(8'hFF, 8'h01, 1'b0, lat);
    checks++;
    if (lat !== 73 || out_sum8 !== 8'h00 || out_cout8 !== 1'b1) begin
      errors++; $display("FAIL carry_ff01: lat=%0d sum=%h cout=%0b required 73/00/1", lat, out_sum8, out_cout8);
    end
    accept_out8();
    run_op8(8'hFF, 8'hFF, 1'b1, lat);
    checks++;
    if (lat !== 73 || out_sum8 !== 8'hFF || out_cout8 !== 1'b1) begin
      errors++; $display("FAIL carry_ffff1: lat=%0d sum=%h cout=%0b required 73/ff/1", lat, out_sum8, out_cout8);
    end
    accept_out8();
  endtask

  task automatic test_cin_only();
    int lat, base, ones;
    base = cin_q.size();
    run_op8(8'h00, 8'h00, 1'b1, lat);
    checks++;
    if (out_sum8 !== 8'h01 || out_cout8 !== 1'b0) begin
      errors++; $display("FAIL cin_only_sum: got %h/%0b required 01/0", out_sum8, out_cout8);
    end
    checks++;
    if (cin_q.size() <= base || cin_q[base] !== 1'b1) begin
      errors++; $display("FAIL cin_first: first strobe fa_cin not 1 (strobes=%0d)", cin_q.size() - base);
    end
    ones = 0;
    for (int i = base + 1; i < cin_q.size(); i++) if (cin_q[i] === 1'b1) ones++;
    checks++;
    if (ones !== 0 || cin_q.size() - base !== 8) begin
      errors++; $display("FAIL cin_later: later fa_cin ones=%0d strobes=%0d required 0/8", ones, cin_q.size() - base);
    end
    accept_out8();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op8(8'hA5, 8'h5A, 1'b1, lat);
    checks++;
    if (lat !== 73) begin errors++; $display("FAIL bp_latency: got %0d required 73", lat); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid8 !== 1'b1 || out_sum8 !== 8'h00 || out_cout8 !== 1'b1 || in_ready8 !== 1'b0) begin
        errors++; $display("FAIL bp_hold: valid=%0b sum=%h cout=%0b in_ready=%0b required 1/00/1/0",
          out_valid8, out_sum8, out_cout8, in_ready8);
      end
    end
    accept_out8();
  endtask

  task automatic test_reset_midop();
    int g, n, lat, base;
    base = strobe_q.size();
    @(negedge clk);
    in_a8 = 8'hC3; in_b8 = 8'h3C; in_cin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid8 = 1'b0;
    g = 0;
    while (strobe_q.size() - base < 4 && g < 100) begin @(negedge clk); g++; end
    checks++;
    if (strobe_q.size() - base !== 4) begin
      errors++; $display("FAIL midop_reach_bit3: strobes=%0d required 4", strobe_q.size() - base);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || fa_strobe8 !== 1'b0) begin
      errors++; $display("FAIL midop_reset: in_ready=%0b out_valid=%0b strobe=%0b required 1/0/0",
        in_ready8, out_valid8, fa_strobe8);
    end
    @(negedge clk); rst = 1'b0;
    n = strobe_q.size();
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (strobe_q.size() !== n || out_valid8 !== 1'b0) begin
      errors++; $display("FAIL midop_quiet: extra strobes=%0d out_valid=%0b required 0/0", strobe_q.size() - n, out_valid8);
    end
    run_op8(8'h10, 8'h20, 1'b0, lat);
    checks++;
    if (lat !== 73 || out_sum8 !== 8'h30 || out_cout8 !== 1'b0) begin
      errors++; $display("FAIL midop_after: lat=%0d sum=%h cout=%0b required 73/30/0", lat, out_sum8, out_cout8);
    end
    accept_out8();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op8(8'h80, 8'h80, 1'b0, lat);
    checks++;
    if (lat !== 73 || out_sum8 !== 8'h00 || out_cout8 !== 1'b1) begin
      errors++; $display("FAIL b2b_first: lat=%0d sum=%h cout=%0b required 73/00/1", lat, out_sum8, out_cout8);
    end
    accept_out8();
    run_op8(8'h7F, 8'h01, 1'b0, lat);
    checks++;
    if (lat !== 73 || out_sum8 !== 8'h80 || out_cout8 !== 1'b0) begin
      errors++; $display("FAIL b2b_second: lat=%0d sum=%h cout=%0b required 73/80/0", lat, out_sum8, out_cout8);
    end
    accept_out8();
  endtask

  task automatic test_corner_w1();
    int lat, s0;
    s0 = strobe1_cnt;
    run_op1(1'b1, 1'b1, 1'b1, lat);
    checks++;
    if (lat !== 3 || out_sum1 !== 1'b1 || out_cout1 !== 1'b1) begin
      errors++; $display("FAIL w1_111: lat=%0d sum=%0b cout=%0b required 3/1/1", lat, out_sum1, out_cout1);
    end
    checks++;
    if (strobe1_cnt - s0 !== 1) begin
      errors++; $display("FAIL w1_strobes: got %0d required 1", strobe1_cnt - s0);
    end
    @(negedge clk); out_ready1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      errors++; $display("FAIL w1_accept: out_valid=%0b in_ready=%0b required 0/1", out_valid1, in_ready1);
    end
    @(negedge clk); out_ready1 = 1'b0;
    run_op1(1'b0, 1'b1, 1'b0, lat);
    checks++;
    if (lat !== 3 || out_sum1 !== 1'b1 || out_cout1 !== 1'b0) begin
      errors++; $display("FAIL w1_010: lat=%0d sum=%0b cout=%0b required 3/1/0", lat, out_sum1, out_cout1);
    end
    @(negedge clk); out_ready1 = 1'b1;
    @(negedge clk); out_ready1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry();
    test_cin_only();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_corner_w1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
